// File: rtl/sobel_window_scheduler_if.sv
// sobel_window_scheduler_if: pixel-in / window-word-out stream bundle.
interface sobel_window_scheduler_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0] in_px;
    logic                   in_valid;
    logic                   in_ready;
    logic [PIXEL_WIDTH-1:0] out_px;
    logic                   out_valid;
    modport master (output in_px, in_valid, input in_ready, out_px, out_valid);
    modport slave  (input in_px, in_valid, output in_ready, out_px, out_valid);
endinterface

// File: rtl/sobel_window_scheduler.sv
// sobel_window_scheduler: turns a raster pixel stream into serial 3x3 window columns for the Sobel engine.
module sobel_window_scheduler #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 160,
    parameter int IMG_HEIGHT  = 120,
    parameter int COL_BITS    = $clog2(IMG_WIDTH),
    parameter int ROW_BITS    = $clog2(IMG_HEIGHT)
) (
    input  logic                           clk_i,
    input  logic                           nreset_i,
    input  logic                           start_frame_i,
    sobel_window_scheduler_if.slave        bus,
    output logic                           start_sobel_o,
    output logic                           busy_o,
    output logic                           frame_done_o
);
    typedef enum logic [2:0] {IDLE, ACCEPT, EMIT, ROW_GAP, DONE} state_t;
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_HEIGHT - 1);
    state_t                 state;
    logic [COL_BITS-1:0]    col;
    logic [ROW_BITS-1:0]    row;
    logic [1:0]             emit;
    logic [PIXEL_WIDTH-1:0] mid, bot;
    logic [PIXEL_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic                   xfer;
    assign xfer = bus.in_ready && bus.in_valid;
    // Line buffers are plain storage, left unreset so they can map to RAM.
    always_ff @(posedge clk_i) begin
        if (xfer) begin
            lb0[col] <= lb1[col];
            lb1[col] <= bus.in_px;
        end
    end
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            emit          <= '0;
            mid           <= '0;
            bot           <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_px    <= '0;
            start_sobel_o <= 1'b0;
            busy_o        <= 1'b0;
            frame_done_o  <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_px    <= '0;
            frame_done_o  <= 1'b0;
            case (state)
                IDLE: if (start_frame_i) begin
                    state         <= ACCEPT;
                    row           <= '0;
                    col           <= '0;
                    bus.in_ready  <= 1'b1;
                    busy_o        <= 1'b1;
                    start_sobel_o <= 1'b0;
                end
                ACCEPT: if (bus.in_valid) begin
                    if (row >= ROW_BITS'(2)) begin
                        // top word goes straight out; mid/bot wait their turn
                        state         <= EMIT;
                        emit          <= '0;
                        bus.in_ready  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.out_px    <= lb0[col];
                        mid           <= lb1[col];
                        bot           <= bus.in_px;
                    end else if (col == LAST_COL) begin
                        col           <= '0;
                        row           <= row + 1'b1;
                        start_sobel_o <= row == ROW_BITS'(1);
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                EMIT: begin
                    emit <= emit + 1'b1;
                    if (emit != 2'd2) begin
                        bus.out_valid <= 1'b1;
                        bus.out_px    <= emit == 2'd0 ? mid : bot;
                    end else if (col != LAST_COL) begin
                        col          <= col + 1'b1;
                        state        <= ACCEPT;
                        bus.in_ready <= 1'b1;
                    end else begin
                        col           <= '0;
                        state         <= ROW_GAP;
                        start_sobel_o <= 1'b0;
                    end
                end
                ROW_GAP: if (row == LAST_ROW) begin
                    state        <= DONE;
                    frame_done_o <= 1'b1;
                end else begin
                    row           <= row + 1'b1;
                    state         <= ACCEPT;
                    bus.in_ready  <= 1'b1;
                    start_sobel_o <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sobel_window_scheduler.sv
// tb_sobel_window_scheduler: scoreboard bench for a 4x4 and a 3x3 scheduler instance.
module tb_sobel_window_scheduler;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic [1:0] sf = '0;
    logic vld = 1'b0;
    logic [7:0] px = '0;
    int sel = 0;
    int errors = 0;
    int checks = 0;
    logic [1:0] ss, bz, fd;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] img[16];
    int k[2] = '{0, 0};
    int low[2] = '{0, 0};
    int fdc[2] = '{0, 0};

    always #5 clk = ~clk;

    sobel_window_scheduler_if #(.PIXEL_WIDTH(8)) ba();
    sobel_window_scheduler_if #(.PIXEL_WIDTH(8)) bb();
    assign ba.in_px = px;
    assign bb.in_px = px;
    assign ba.in_valid = vld && sel == 0;
    assign bb.in_valid = vld && sel == 1;

    sobel_window_scheduler #(.PIXEL_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk_i(clk), .nreset_i(nrst), .start_frame_i(sf[0]), .bus(ba),
        .start_sobel_o(ss[0]), .busy_o(bz[0]), .frame_done_o(fd[0]));
    sobel_window_scheduler #(.PIXEL_WIDTH(8), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut_b (
        .clk_i(clk), .nreset_i(nrst), .start_frame_i(sf[1]), .bus(bb),
        .start_sobel_o(ss[1]), .busy_o(bz[1]), .frame_done_o(fd[1]));

    wire [1:0] ov = {bb.out_valid, ba.out_valid};
    wire [1:0] rd = {bb.in_ready, ba.in_ready};
    wire [1:0] vl = {bb.in_valid, ba.in_valid};

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every valid word and checks the strobe rules.
    initial begin
        int wd, r, c;
        logic [7:0] got, want;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) if (nrst) begin
                wd = i ? 3 : 4;
                if (!bz[i]) k[i] = 0;
                if (rd[i] && vl[i]) begin
                    r = k[i] / wd;
                    c = k[i] % wd;
                    chk(ss[i] == (r >= 2), "sobel_at_accept", int'(ss[i]), int'(r >= 2));
                    if (r >= 3 && c == 0) chk(low[i] == 1, "row_gap_low_cycles", low[i], 1);
                    k[i]++;
                end
                if (ov[i]) begin
                    got = i ? bb.out_px : ba.out_px;
                    chk(!rd[i], "ready_during_emit", int'(rd[i]), 0);
                    chk(ss[i], "sobel_during_emit", int'(ss[i]), 1);
                    if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0))
                        chk(1'b0, "unexpected_word", int'(got), -1);
                    else begin
                        if (i == 0) want = qa.pop_front();
                        else want = qb.pop_front();
                        chk(got == want, "window_word", int'(got), int'(want));
                    end
                    low[i] = 0;
                end else if (!ss[i]) low[i]++;
                if (fd[i]) fdc[i]++;
            end
        end
    end

    task automatic feed(input int n, input bit gaps, input bit pulse);
        int i = 0;
        int cyc = 0;
        bit x;
        while (i < n && cyc < 2000) begin
            vld = gaps ? 1'($urandom % 2) : 1'b1;
            px = img[i];
            sf[sel] = pulse && i == 5;
            @(negedge clk);
            x = rd[sel] && vl[sel];
            @(posedge clk); #1;
            if (x) i++;
            cyc++;
        end
        vld = 1'b0;
        sf = '0;
        if (i < n) chk(1'b0, "feed_timeout", i, n);
    endtask

    task automatic frame(input int s, input bit rnd, input bit gaps, input bit pulse, input bit abort);
        int w = s ? 3 : 4;
        int f0;
        int cyc = 0;
        sel = s;
        for (int r = 0; r < w; r++)
            for (int c = 0; c < w; c++)
                img[r*w+c] = rnd ? 8'($urandom) : (s ? 8'(r*w+c+1) : 8'(16*r+c));
        if (!abort)
            for (int r = 2; r < w; r++)
                for (int c = 0; c < w; c++)
                    for (int t = 2; t >= 0; t--)
                        if (s == 0) qa.push_back(img[(r-t)*w+c]);
                        else qb.push_back(img[(r-t)*w+c]);
        f0 = fdc[s];
        @(posedge clk); #1;
        sf[s] = 1'b1;
        @(posedge clk); #1;
        sf[s] = 1'b0;
        if (abort) begin
            feed(2*w+1, 1'b0, 1'b0);
            chk(ba.out_valid == 1'b1, "emit_word1_before_reset", int'(ba.out_valid), 1);
            nrst = 1'b0;
            #1;
            chk({ba.out_valid, ba.out_px, ba.in_ready, ss[0], bz[0], fd[0]} == 13'd0, "abort_outputs",
                int'({ba.out_valid, ba.out_px, ba.in_ready, ss[0], bz[0], fd[0]}), 0);
            @(posedge clk); #1;
            nrst = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk({bz[0], ba.in_ready} == 2'b00, "idle_after_abort", int'({bz[0], ba.in_ready}), 0);
            return;
        end
        feed(w*w, gaps, pulse);
        while (!fd[s] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(fd[s] == 1'b1, "frame_done_seen", int'(fd[s]), 1);
        sf[s] = pulse;
        @(posedge clk); #1;
        sf[s] = 1'b0;
        chk(bz[s] == 1'b0, "busy_clear_after_done", int'(bz[s]), 0);
        repeat (4) @(posedge clk);
        #1;
        chk(bz[s] == 1'b0, "stays_idle", int'(bz[s]), 0);
        chk(fdc[s] - f0 == 1, "frame_done_count", fdc[s] - f0, 1);
        chk((s ? qb.size() : qa.size()) == 0, "words_missing", s ? qb.size() : qa.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk({ba.out_valid, ba.out_px, ba.in_ready, ss[0], bz[0], fd[0]} == 13'd0, "reset_outputs_a",
            int'({ba.out_valid, ba.out_px, ba.in_ready, ss[0], bz[0], fd[0]}), 0);
        chk({bb.out_valid, bb.out_px, bb.in_ready, ss[1], bz[1], fd[1]} == 13'd0, "reset_outputs_b",
            int'({bb.out_valid, bb.out_px, bb.in_ready, ss[1], bz[1], fd[1]}), 0);
        nrst = 1'b1;
        frame(0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(0, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(0, 1'b1, 1'b1, 1'b0, 1'b0);
        frame(0, 1'b0, 1'b0, 1'b1, 1'b0);
        frame(0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1, 1'b1, 1'b1, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
